axi_lite_mgr_seq: RTL
=====================

# axi_lite_mgr_seq

Single-outstanding AXI-Lite manager sequencer. Accepts one read or write command at a time on a simple command port and drives the AW/W/B or AR/R channels toward one subordinate. It follows the AXI-Lite handshake rules and returns the response code (and read data) as a one-cycle response pulse. A programmable watchdog aborts transactions the subordinate never completes.

## Interface
- ADDRESS_WIDTH, 32, width of address fields
- DATA_WIDTH, 32, width of data fields; STRB_WIDTH = DATA_WIDTH/8 (from axi_pkg)
- TIMEOUT, 1024, watchdog limit in cycles; 0 disables the watchdog
- clk  in  1  single clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer idle, command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDRESS_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  STRB_WIDTH  write strobes (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  out  respCode  BRESP/RRESP, SLVERR on timeout
- rsp_timeout  out  1  transaction aborted by watchdog
- AWVALID/AWREADY/AWADDR  out/in/out  1/1/ADDRESS_WIDTH  write address channel
- WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_WIDTH/STRB_WIDTH  write data channel
- BVALID/BREADY/BRESP  in/out/in  1/1/respCode  write response channel
- ARVALID/ARREADY/ARADDR  out/in/out  1/1/ADDRESS_WIDTH  read address channel
- RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_WIDTH/respCode  read data channel

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: cmd_ready=1. On accept, register addr/wdata/wstrb. Go to WR_REQ (set AWVALID and WVALID) or RD_REQ (set ARVALID).
- WR_REQ: AWVALID and WVALID are dropped independently, each the cycle after its own handshake. AW and W may complete in either order or in the same cycle. When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP and go to DONE.
- RD_REQ: on ARREADY, drop ARVALID and go to RD_RESP. RD_RESP: RREADY=1. On RVALID, capture RDATA/RRESP and go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
- No command is accepted outside IDLE. The command inputs are ignored while busy.
- AWADDR/WDATA/WSTRB/ARADDR hold stable while their VALID is high. VALID never deasserts before its handshake, except on timeout.
- Watchdog counter:
  - Clears on command accept.
  - Increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - When it reaches TIMEOUT (TIMEOUT≠0): deassert all VALID/READY outputs and go to DONE with rsp_timeout=1, rsp_resp=SLVERR, rsp_rdata=0.
  - A handshake in the same cycle as expiry wins; no timeout is taken.
  - The counter saturates and does not wrap.

## Timing
- Reset values: AWVALID=WVALID=ARVALID=BREADY=RREADY=0, rsp_valid=rsp_timeout=0, rsp_rdata=0, rsp_resp=OKAY, addresses/data=0, state IDLE, cmd_ready=1.
- An ARESET asserted mid-transaction returns to these values immediately, and the transaction is lost.
- All AXI outputs and rsp_* are registered. cmd_ready, BREADY and RREADY decode the state register.
- Minimum write latency, with a subordinate always ready and BVALID the cycle after W:
  - accept at cycle 0;
  - AW/W handshake at cycle 1;
  - B handshake at cycle 2;
  - rsp_valid at cycle 3;
  - cmd_ready high again at cycle 4.
- Minimum read latency: accept at cycle 0, AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
- rsp_* fields are valid only while rsp_valid=1 and hold their value until the next DONE.
- The timeout pulse appears at cycle TIMEOUT+1 after accept.

## Test plan
- Write: addr 0x10, data 0xDEADBEEF, strb 0xF, subordinate always ready, BRESP=OKAY -> AW/W at cycle 1, rsp_valid at cycle 3, rsp_resp=OKAY, rsp_timeout=0.
- Write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after cycle 1, AWVALID held with 0x10 stable until its handshake, then one B and one response.
- Read: addr 0x20, RDATA=0x12345678, RRESP=SLVERR, RVALID delayed 2 cycles -> rsp_rdata=0x12345678, rsp_resp=SLVERR, RREADY held high until R.
- TIMEOUT=8, BVALID never asserted -> at cycle 9 BREADY=0, rsp_valid=1, rsp_timeout=1, rsp_resp=SLVERR; next command accepted normally.
- Back-to-back: cmd_valid held high for write then read -> second command accepted only when cmd_ready returns; no overlap on the AXI channels.
- ARESET pulsed while in RD_RESP -> all outputs go to reset values asynchronously and cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_mgr_seq.sv
// Single-outstanding AXI-Lite manager: one read or write in flight, one-cycle
// response pulse, and a watchdog that aborts transactions the subordinate stalls.
module axi_lite_mgr_seq #(
    parameter int  ADDRESS_WIDTH = 32,
    parameter int  DATA_WIDTH    = 32,
    parameter int  TIMEOUT       = 1024,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     ARESET,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [STRB_WIDTH-1:0]    cmd_wstrb,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_timeout,
    output logic                     AWVALID,
    input  logic                     AWREADY,
    output logic [ADDRESS_WIDTH-1:0] AWADDR,
    output logic                     WVALID,
    input  logic                     WREADY,
    output logic [DATA_WIDTH-1:0]    WDATA,
    output logic [STRB_WIDTH-1:0]    WSTRB,
    input  logic                     BVALID,
    output logic                     BREADY,
    input  logic [1:0]               BRESP,
    output logic                     ARVALID,
    input  logic                     ARREADY,
    output logic [ADDRESS_WIDTH-1:0] ARADDR,
    input  logic                     RVALID,
    output logic                     RREADY,
    input  logic [DATA_WIDTH-1:0]    RDATA,
    input  logic [1:0]               RRESP
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] CNT_LAST    = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_timeout;
    logic                     w_accept;
    logic                     w_busy;
    logic                     w_expire;
    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_ar_hs;
    logic                     w_wr_req_done;
    logic [31:0]              r_cnt;
    logic                     r_awvalid;
    logic                     r_wvalid;
    logic                     r_arvalid;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [STRB_WIDTH-1:0]    r_wstrb;
    logic                     r_rsp_valid;
    logic [DATA_WIDTH-1:0]    r_rsp_rdata;
    logic [1:0]               r_rsp_resp;
    logic                     r_rsp_timeout;

    assign w_accept = cmd_valid & cmd_ready;
    assign w_busy   = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                      (r_state == S_RD_REQ) || (r_state == S_RD_RESP);
    // Expiry is flagged in the last cycle so the abort pulse lands at TIMEOUT+1.
    assign w_expire = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
    assign w_aw_hs  = r_awvalid & AWREADY;
    assign w_w_hs   = r_wvalid & WREADY;
    assign w_ar_hs  = r_arvalid & ARREADY;
    assign w_wr_req_done = (w_aw_hs | ~r_awvalid) & (w_w_hs | ~r_wvalid);

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_wr_req_done) begin
                    w_next_state = S_WR_RESP;
                end else if (w_expire) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (BVALID) begin
                    w_next_state = S_DONE;
                end else if (w_expire) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (w_ar_hs) begin
                    w_next_state = S_RD_RESP;
                end else if (w_expire) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (RVALID) begin
                    w_next_state = S_DONE;
                end else if (w_expire) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        BREADY    = (r_state == S_WR_RESP);
        RREADY    = (r_state == S_RD_RESP);
    end

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_busy && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Each VALID falls on its own handshake; a timeout drops them all together.
    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_accept) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_awvalid <= cmd_write;
            r_wvalid  <= cmd_write;
            r_arvalid <= ~cmd_write;
        end else if (w_timeout) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
        end else begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            if (w_ar_hs) r_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge ARESET) begin
        if (ARESET) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_OKAY;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= (w_next_state == S_DONE);
            if (w_timeout) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= RESP_SLVERR;
                r_rsp_timeout <= 1'b1;
            end else if ((r_state == S_WR_RESP) && BVALID) begin
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= BRESP;
                r_rsp_timeout <= 1'b0;
            end else if ((r_state == S_RD_RESP) && RVALID) begin
                r_rsp_rdata   <= RDATA;
                r_rsp_resp    <= RRESP;
                r_rsp_timeout <= 1'b0;
            end
        end
    end

    assign AWVALID     = r_awvalid;
    assign AWADDR      = r_addr;
    assign WVALID      = r_wvalid;
    assign WDATA       = r_wdata;
    assign WSTRB       = r_wstrb;
    assign ARVALID     = r_arvalid;
    assign ARADDR      = r_addr;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;

endmodule
